// File: rtl/ipic_pkg.sv
// ---------------------------------------------------------------------------
// ipic_pkg
// Shared definitions for the single-beat IPIC-lite engine:
//   - command type codes carried on ipic_type
//   - engine state encoding
//   - full-word byte-enable constant
//   - is_single(): true for the two command types that reach the bus
// ---------------------------------------------------------------------------
package ipic_pkg;

    localparam logic [2:0] IPIC_BURST_RD  = 3'd0;
    localparam logic [2:0] IPIC_BURST_WR  = 3'd1;
    localparam logic [2:0] IPIC_SINGLE_RD = 3'd2;
    localparam logic [2:0] IPIC_SINGLE_WR = 3'd3;

    localparam logic [3:0] BE_ALL = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } ipic_state_t;

    // Any code other than the two single-beat types is rejected without
    // touching the bus.
    function automatic logic is_single(input logic [2:0] cmd_type);
        return (cmd_type == IPIC_SINGLE_RD) || (cmd_type == IPIC_SINGLE_WR);
    endfunction

endpackage

// File: rtl/ipic_watchdog.sv
// ---------------------------------------------------------------------------
// ipic_watchdog
// Per-transaction cycle counter. Loaded on clear, advances while enable is
// high, and raises timeout while enabled once the transaction has lasted
// C_TIMEOUT_CYCLES-1 cycles counted from the accept cycle.
//
// Ports:
//   clk      in   system clock
//   reset_n  in   synchronous active-low reset
//   clear    in   restart the count (command accepted)
//   enable   in   transaction is on the bus (REQ/WAIT)
//   timeout  out  limit reached; engine must abort this cycle
// ---------------------------------------------------------------------------
module ipic_watchdog #(
    parameter int unsigned C_TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam int unsigned CNT_W = $clog2(C_TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(C_TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // The accept cycle itself is counted as the first cycle, so the count
    // always equals the number of cycles since the start was taken. The
    // counter parks at the limit so it can never wrap.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= CNT_W'(1);
        end else if (enable && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign timeout = enable && (count == LIMIT);

endmodule

// File: rtl/ipic_single_engine.sv
// ---------------------------------------------------------------------------
// ipic_single_engine
// Executes one single-beat IPIC-lite read or write per ipic_start command and
// reports completion with a one-cycle ipic_done pulse plus an error flag.
// Burst command types are rejected with an error and never reach the bus.
//
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   ipic_start/ipic_type         one-cycle command strobe and command type
//   read_addr/write_addr         address used for single read / single write
//   write_data                   data for single write
//   ipic_done/busy/error         completion pulse, busy, last-transaction status
//   single_read_data             last captured read beat
//   ip2bus_*                     IPIC master request side
//   bus2ip_*                     IPIC master status/data side
//   stat_rd/wr/err_count         completion counters (IPIC_STATS_EN), else 0
//
// Optional feature: define IPIC_STATS_EN to build the saturating 16-bit
// completion counters; otherwise the stat ports are tied to zero.
// ---------------------------------------------------------------------------
module ipic_single_engine
    import ipic_pkg::*;
#(
    parameter int unsigned C_ADDR_WIDTH     = 32,
    parameter int unsigned C_DATA_WIDTH     = 32,
    parameter int unsigned C_LENGTH_WIDTH   = 12,
    parameter int unsigned C_TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      ipic_start,
    input  logic [2:0]                ipic_type,
    input  logic [C_ADDR_WIDTH-1:0]   read_addr,
    input  logic [C_ADDR_WIDTH-1:0]   write_addr,
    input  logic [C_DATA_WIDTH-1:0]   write_data,
    output logic                      ipic_done,
    output logic                      ipic_busy,
    output logic                      ipic_error,
    output logic [C_DATA_WIDTH-1:0]   single_read_data,
    output logic                      ip2bus_mstrd_req,
    output logic                      ip2bus_mstwr_req,
    output logic [C_ADDR_WIDTH-1:0]   ip2bus_mst_addr,
    output logic [C_DATA_WIDTH/8-1:0] ip2bus_mst_be,
    output logic                      ip2bus_mst_lock,
    output logic                      ip2bus_mst_reset,
    output logic [C_DATA_WIDTH-1:0]   ip2bus_mstwr_d,
    input  logic                      bus2ip_mst_cmdack,
    input  logic                      bus2ip_mst_cmplt,
    input  logic                      bus2ip_mst_error,
    input  logic                      bus2ip_mst_rearbitrate,
    input  logic                      bus2ip_mst_cmd_timeout,
    input  logic [C_DATA_WIDTH-1:0]   bus2ip_mstrd_d,
    input  logic                      bus2ip_mstrd_src_rdy_n,
    input  logic                      bus2ip_mstwr_dst_rdy_n,
    output logic [15:0]               stat_rd_count,
    output logic [15:0]               stat_wr_count,
    output logic [15:0]               stat_err_count
);

    // The byte-enable logic assumes a single 32-bit lane; the length width
    // only exists for port compatibility with the burst-capable engines.
    generate
        if ((C_DATA_WIDTH != 32) || (C_LENGTH_WIDTH < 1)) begin : g_bad_config
            $error("ipic_single_engine supports only a 32-bit data path");
        end
    endgenerate

    ipic_state_t state;
    ipic_state_t next_state;

    logic [2:0]              type_q;
    logic [C_ADDR_WIDTH-1:0] addr_q;
    logic [C_DATA_WIDTH-1:0] wdata_q;
    logic [C_DATA_WIDTH-1:0] rd_data_q;
    logic                    rearb_hold;
    logic                    err_q;
    logic                    done_q;
    logic                    mst_reset_q;
    logic                    wr_beat_q;

    logic accept;
    logic in_bus;
    logic is_rd;
    logic is_wr;
    logic wd_timeout;
    logic rearb_start;
    logic cmplt_take;

    assign accept = (state == IDLE) && ipic_start;
    assign in_bus = (state == REQ) || (state == WAIT);
    assign is_rd  = (type_q == IPIC_SINGLE_RD);
    assign is_wr  = (type_q == IPIC_SINGLE_WR);

    // Rearbitration during REQ is ignored while the one-cycle request gap
    // from a previous rearbitration is still in progress.
    assign rearb_start = !wd_timeout && bus2ip_mst_rearbitrate &&
                         (((state == REQ) && !rearb_hold) || (state == WAIT));

    // Completion is taken either in WAIT or in the same REQ cycle as the
    // command acknowledge (the minimum-latency path).
    assign cmplt_take = !wd_timeout && !rearb_start && bus2ip_mst_cmplt &&
                        (((state == REQ) && !rearb_hold && bus2ip_mst_cmdack) ||
                         (state == WAIT));

    ipic_watchdog #(
        .C_TIMEOUT_CYCLES(C_TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (accept),
        .enable  (in_bus),
        .timeout (wd_timeout)
    );

    // State register plus all registered status. ipic_done is the delayed
    // image of the DONE state, so the done cycle is already IDLE and busy
    // drops together with the pulse.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            type_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_data_q   <= '0;
            rearb_hold  <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            mst_reset_q <= 1'b0;
            wr_beat_q   <= 1'b0;
        end else begin
            state       <= next_state;
            done_q      <= (state == DONE);
            mst_reset_q <= wd_timeout;
            rearb_hold  <= rearb_start;

            if (accept) begin
                type_q    <= ipic_type;
                addr_q    <= (ipic_type == IPIC_SINGLE_WR) ? write_addr : read_addr;
                wdata_q   <= write_data;
                err_q     <= !is_single(ipic_type);
                wr_beat_q <= 1'b0;
            end else begin
                if (wd_timeout) begin
                    err_q <= 1'b1;
                end else if (cmplt_take) begin
                    err_q <= bus2ip_mst_error | bus2ip_mst_cmd_timeout;
                end
                if (in_bus && is_wr && !bus2ip_mstwr_dst_rdy_n) begin
                    wr_beat_q <= 1'b1;
                end
            end

            // A beat arriving in the abort cycle is discarded so a timed-out
            // read leaves the previous data intact.
            if (in_bus && is_rd && !bus2ip_mstrd_src_rdy_n && !wd_timeout) begin
                rd_data_q <= bus2ip_mstrd_d;
            end
        end
    end

    // Next-state logic. The watchdog abort has priority over everything,
    // then rearbitration, then the normal acknowledge/complete handshake.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (ipic_start) begin
                    next_state = is_single(ipic_type) ? REQ : DONE;
                end
            end
            REQ: begin
                if (wd_timeout) begin
                    next_state = DONE;
                end else if (rearb_hold || rearb_start) begin
                    next_state = REQ;
                end else if (bus2ip_mst_cmdack) begin
                    next_state = bus2ip_mst_cmplt ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (wd_timeout) begin
                    next_state = DONE;
                end else if (rearb_start) begin
                    next_state = REQ;
                end else if (bus2ip_mst_cmplt) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign ip2bus_mstrd_req = (state == REQ) && !rearb_hold && is_rd;
    assign ip2bus_mstwr_req = (state == REQ) && !rearb_hold && is_wr;
    assign ip2bus_mst_addr  = in_bus ? addr_q : '0;
    assign ip2bus_mst_be    = in_bus ? BE_ALL : '0;
    assign ip2bus_mstwr_d   = (in_bus && is_wr && !wr_beat_q) ? wdata_q : '0;
    assign ip2bus_mst_lock  = 1'b0;
    assign ip2bus_mst_reset = mst_reset_q;

    assign ipic_busy        = (state != IDLE);
    assign ipic_done        = done_q;
    assign ipic_error       = err_q;
    assign single_read_data = rd_data_q;

`ifdef IPIC_STATS_EN
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;
    logic [15:0] err_cnt;

    // Counters advance in the DONE cycle so the new totals appear together
    // with the ipic_done pulse; each sticks at all-ones.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            err_cnt <= '0;
        end else if (state == DONE) begin
            if (is_rd && (rd_cnt != 16'hFFFF)) begin
                rd_cnt <= rd_cnt + 16'd1;
            end
            if (is_wr && (wr_cnt != 16'hFFFF)) begin
                wr_cnt <= wr_cnt + 16'd1;
            end
            if (err_q && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end

    assign stat_rd_count  = rd_cnt;
    assign stat_wr_count  = wr_cnt;
    assign stat_err_count = err_cnt;
`else
    assign stat_rd_count  = '0;
    assign stat_wr_count  = '0;
    assign stat_err_count = '0;
`endif

endmodule

// File: tb/tb_ipic_single_engine.sv
// ---------------------------------------------------------------------------
// tb_ipic_single_engine
// Directed bench for ipic_single_engine with a 16-cycle watchdog. Cycle c0 is
// the cycle ipic_start is high; inputs are driven and outputs sampled 1 time
// unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_ipic_single_engine;
    import ipic_pkg::*;

`ifdef IPIC_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ipic_start;
    logic [2:0]  ipic_type;
    logic [31:0] read_addr;
    logic [31:0] write_addr;
    logic [31:0] write_data;
    logic        ipic_done;
    logic        ipic_busy;
    logic        ipic_error;
    logic [31:0] single_read_data;
    logic        ip2bus_mstrd_req;
    logic        ip2bus_mstwr_req;
    logic [31:0] ip2bus_mst_addr;
    logic [3:0]  ip2bus_mst_be;
    logic        ip2bus_mst_lock;
    logic        ip2bus_mst_reset;
    logic [31:0] ip2bus_mstwr_d;
    logic        bus2ip_mst_cmdack;
    logic        bus2ip_mst_cmplt;
    logic        bus2ip_mst_error;
    logic        bus2ip_mst_rearbitrate;
    logic        bus2ip_mst_cmd_timeout;
    logic [31:0] bus2ip_mstrd_d;
    logic        bus2ip_mstrd_src_rdy_n;
    logic        bus2ip_mstwr_dst_rdy_n;
    logic [15:0] stat_rd_count;
    logic [15:0] stat_wr_count;
    logic [15:0] stat_err_count;

    int total_count = 0;
    int bad_count   = 0;

    always #5 clk = ~clk;

    ipic_single_engine #(
        .C_ADDR_WIDTH     (32),
        .C_DATA_WIDTH     (32),
        .C_LENGTH_WIDTH   (12),
        .C_TIMEOUT_CYCLES (16)
    ) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .ipic_start             (ipic_start),
        .ipic_type              (ipic_type),
        .read_addr              (read_addr),
        .write_addr             (write_addr),
        .write_data             (write_data),
        .ipic_done              (ipic_done),
        .ipic_busy              (ipic_busy),
        .ipic_error             (ipic_error),
        .single_read_data       (single_read_data),
        .ip2bus_mstrd_req       (ip2bus_mstrd_req),
        .ip2bus_mstwr_req       (ip2bus_mstwr_req),
        .ip2bus_mst_addr        (ip2bus_mst_addr),
        .ip2bus_mst_be          (ip2bus_mst_be),
        .ip2bus_mst_lock        (ip2bus_mst_lock),
        .ip2bus_mst_reset       (ip2bus_mst_reset),
        .ip2bus_mstwr_d         (ip2bus_mstwr_d),
        .bus2ip_mst_cmdack      (bus2ip_mst_cmdack),
        .bus2ip_mst_cmplt       (bus2ip_mst_cmplt),
        .bus2ip_mst_error       (bus2ip_mst_error),
        .bus2ip_mst_rearbitrate (bus2ip_mst_rearbitrate),
        .bus2ip_mst_cmd_timeout (bus2ip_mst_cmd_timeout),
        .bus2ip_mstrd_d         (bus2ip_mstrd_d),
        .bus2ip_mstrd_src_rdy_n (bus2ip_mstrd_src_rdy_n),
        .bus2ip_mstwr_dst_rdy_n (bus2ip_mstwr_dst_rdy_n),
        .stat_rd_count          (stat_rd_count),
        .stat_wr_count          (stat_wr_count),
        .stat_err_count         (stat_err_count)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        total_count++;
        if (actual !== expected) begin
            bad_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic busIdle();
        bus2ip_mst_cmdack      = 1'b0;
        bus2ip_mst_cmplt       = 1'b0;
        bus2ip_mst_error       = 1'b0;
        bus2ip_mst_rearbitrate = 1'b0;
        bus2ip_mst_cmd_timeout = 1'b0;
        bus2ip_mstrd_d         = 32'h0;
        bus2ip_mstrd_src_rdy_n = 1'b1;
        bus2ip_mstwr_dst_rdy_n = 1'b1;
    endtask

    // Drives one start cycle (c0) and returns at the beginning of c1.
    task automatic applyStimulus(input logic [2:0] cmd, input logic [31:0] ra,
                                 input logic [31:0] wa, input logic [31:0] wd);
        ipic_start = 1'b1;
        ipic_type  = cmd;
        read_addr  = ra;
        write_addr = wa;
        write_data = wd;
        nextCycle();
        ipic_start = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        ipic_start = 1'b0;
        ipic_type  = 3'd0;
        read_addr  = 32'h0;
        write_addr = 32'h0;
        write_data = 32'h0;
        busIdle();
        repeat (3) nextCycle();

        // Reset state
        checkOutput("rst_done",  32'(ipic_done), 32'd0);
        checkOutput("rst_busy",  32'(ipic_busy), 32'd0);
        checkOutput("rst_error", 32'(ipic_error), 32'd0);
        checkOutput("rst_rdreq", 32'(ip2bus_mstrd_req), 32'd0);
        checkOutput("rst_wrreq", 32'(ip2bus_mstwr_req), 32'd0);
        checkOutput("rst_addr",  ip2bus_mst_addr, 32'd0);
        checkOutput("rst_be",    32'(ip2bus_mst_be), 32'd0);
        checkOutput("rst_mrst",  32'(ip2bus_mst_reset), 32'd0);
        checkOutput("rst_rdata", single_read_data, 32'd0);
        reset_n = 1'b1;
        nextCycle();

        // Single read: cmdack at c2, data+cmplt at c4, done at c6
        applyStimulus(IPIC_SINGLE_RD, 32'h60004038, 32'h0, 32'h0);
        checkOutput("rd_busy_c1", 32'(ipic_busy), 32'd1);
        checkOutput("rd_req_c1",  32'(ip2bus_mstrd_req), 32'd1);
        checkOutput("rd_addr_c1", ip2bus_mst_addr, 32'h60004038);
        checkOutput("rd_be_c1",   32'(ip2bus_mst_be), 32'hF);
        nextCycle();
        bus2ip_mst_cmdack = 1'b1;
        checkOutput("rd_req_c2", 32'(ip2bus_mstrd_req), 32'd1);
        nextCycle();
        busIdle();
        checkOutput("rd_req_c3", 32'(ip2bus_mstrd_req), 32'd0);
        nextCycle();
        bus2ip_mstrd_d = 32'h00000002;
        bus2ip_mstrd_src_rdy_n = 1'b0;
        bus2ip_mst_cmplt = 1'b1;
        nextCycle();
        busIdle();
        checkOutput("rd_done_c5", 32'(ipic_done), 32'd0);
        checkOutput("rd_busy_c5", 32'(ipic_busy), 32'd1);
        nextCycle();
        checkOutput("rd_done_c6",  32'(ipic_done), 32'd1);
        checkOutput("rd_err_c6",   32'(ipic_error), 32'd0);
        checkOutput("rd_data_c6",  single_read_data, 32'h00000002);
        checkOutput("rd_busy_c6",  32'(ipic_busy), 32'd0);
        nextCycle();
        checkOutput("rd_done_c7", 32'(ipic_done), 32'd0);
        nextCycle();

        // Single write: cmdack at c1, beat at c2, cmplt at c3, done at c5
        applyStimulus(IPIC_SINGLE_WR, 32'h11111111, 32'h60000080, 32'hDEADBEEF);
        checkOutput("wr_req_c1",   32'(ip2bus_mstwr_req), 32'd1);
        checkOutput("wr_rdreq_c1", 32'(ip2bus_mstrd_req), 32'd0);
        checkOutput("wr_data_c1",  ip2bus_mstwr_d, 32'hDEADBEEF);
        checkOutput("wr_addr_c1",  ip2bus_mst_addr, 32'h60000080);
        checkOutput("wr_be_c1",    32'(ip2bus_mst_be), 32'hF);
        bus2ip_mst_cmdack = 1'b1;
        nextCycle();
        busIdle();
        checkOutput("wr_req_c2",  32'(ip2bus_mstwr_req), 32'd0);
        checkOutput("wr_data_c2", ip2bus_mstwr_d, 32'hDEADBEEF);
        bus2ip_mstwr_dst_rdy_n = 1'b0;
        nextCycle();
        busIdle();
        bus2ip_mst_cmplt = 1'b1;
        nextCycle();
        busIdle();
        checkOutput("wr_done_c4", 32'(ipic_done), 32'd0);
        nextCycle();
        checkOutput("wr_done_c5", 32'(ipic_done), 32'd1);
        checkOutput("wr_err_c5",  32'(ipic_error), 32'd0);
        nextCycle();

        // Rearbitrate in REQ: request low exactly at c2, back at c3
        applyStimulus(IPIC_SINGLE_RD, 32'h60000010, 32'h0, 32'h0);
        checkOutput("rarb_req_c1", 32'(ip2bus_mstrd_req), 32'd1);
        bus2ip_mst_rearbitrate = 1'b1;
        nextCycle();
        busIdle();
        checkOutput("rarb_req_c2", 32'(ip2bus_mstrd_req), 32'd0);
        nextCycle();
        checkOutput("rarb_req_c3", 32'(ip2bus_mstrd_req), 32'd1);
        bus2ip_mst_cmdack = 1'b1;
        bus2ip_mst_cmplt = 1'b1;
        bus2ip_mstrd_src_rdy_n = 1'b0;
        bus2ip_mstrd_d = 32'hA5A50001;
        nextCycle();
        busIdle();
        checkOutput("rarb_req_c4",  32'(ip2bus_mstrd_req), 32'd0);
        checkOutput("rarb_busy_c4", 32'(ipic_busy), 32'd1);
        nextCycle();
        checkOutput("rarb_done_c5", 32'(ipic_done), 32'd1);
        checkOutput("rarb_err_c5",  32'(ipic_error), 32'd0);
        checkOutput("rarb_data_c5", single_read_data, 32'hA5A50001);
        nextCycle();

        // Minimum latency write: cmdack+cmplt at c1, done at c3
        applyStimulus(IPIC_SINGLE_WR, 32'h0, 32'h60000084, 32'h12345678);
        checkOutput("min_req_c1", 32'(ip2bus_mstwr_req), 32'd1);
        bus2ip_mst_cmdack = 1'b1;
        bus2ip_mst_cmplt = 1'b1;
        bus2ip_mstwr_dst_rdy_n = 1'b0;
        nextCycle();
        busIdle();
        checkOutput("min_done_c2", 32'(ipic_done), 32'd0);
        nextCycle();
        checkOutput("min_done_c3", 32'(ipic_done), 32'd1);
        checkOutput("min_err_c3",  32'(ipic_error), 32'd0);
        nextCycle();

        // Silent slave: abort at count 15, mst_reset at c16, done at c17;
        // the start issued at c8 while busy must be dropped.
        applyStimulus(IPIC_SINGLE_RD, 32'h60000020, 32'h60000090, 32'h0);
        for (int c = 1; c <= 19; c++) begin
            ipic_start = (c == 8);
            ipic_type  = IPIC_SINGLE_WR;
            if (c == 15 || c == 16)
                checkOutput($sformatf("to_req_c%0d", c), 32'(ip2bus_mstrd_req),
                            (c == 15) ? 32'd1 : 32'd0);
            if (c >= 15 && c <= 17)
                checkOutput($sformatf("to_mrst_c%0d", c), 32'(ip2bus_mst_reset),
                            (c == 16) ? 32'd1 : 32'd0);
            if (c >= 16 && c <= 18)
                checkOutput($sformatf("to_done_c%0d", c), 32'(ipic_done),
                            (c == 17) ? 32'd1 : 32'd0);
            if (c == 17) begin
                checkOutput("to_err_c17",  32'(ipic_error), 32'd1);
                checkOutput("to_data_c17", single_read_data, 32'hA5A50001);
            end
            if (c == 19) begin
                checkOutput("to_busy_c19",  32'(ipic_busy), 32'd0);
                checkOutput("to_wrreq_c19", 32'(ip2bus_mstwr_req), 32'd0);
            end
            nextCycle();
        end
        ipic_start = 1'b0;

        // Three reads, two writes, one error so far
        checkOutput("stat_rd",  32'(stat_rd_count),  STATS ? 32'd3 : 32'd0);
        checkOutput("stat_wr",  32'(stat_wr_count),  STATS ? 32'd2 : 32'd0);
        checkOutput("stat_err", 32'(stat_err_count), STATS ? 32'd1 : 32'd0);

        // Burst write: no request, done at c2 with error
        applyStimulus(IPIC_BURST_WR, 32'h60000000, 32'h60000000, 32'h0);
        checkOutput("bwr_req_c1",  32'(ip2bus_mstwr_req | ip2bus_mstrd_req), 32'd0);
        checkOutput("bwr_busy_c1", 32'(ipic_busy), 32'd1);
        checkOutput("bwr_done_c1", 32'(ipic_done), 32'd0);
        nextCycle();
        checkOutput("bwr_done_c2", 32'(ipic_done), 32'd1);
        checkOutput("bwr_err_c2",  32'(ipic_error), 32'd1);
        checkOutput("bwr_req_c2",  32'(ip2bus_mstwr_req | ip2bus_mstrd_req), 32'd0);
        nextCycle();
        checkOutput("bwr_done_c3", 32'(ipic_done), 32'd0);

        // Burst read behaves the same
        applyStimulus(IPIC_BURST_RD, 32'h60000000, 32'h0, 32'h0);
        checkOutput("brd_req_c1", 32'(ip2bus_mstrd_req), 32'd0);
        nextCycle();
        checkOutput("brd_done_c2", 32'(ipic_done), 32'd1);
        checkOutput("brd_err_c2",  32'(ipic_error), 32'd1);
        nextCycle();

        // Read completing with cmd_timeout: error reported and held
        applyStimulus(IPIC_SINGLE_RD, 32'h60000030, 32'h0, 32'h0);
        checkOutput("ert_err_c1", 32'(ipic_error), 32'd0);
        bus2ip_mst_cmdack = 1'b1;
        nextCycle();
        busIdle();
        bus2ip_mst_cmplt = 1'b1;
        bus2ip_mst_cmd_timeout = 1'b1;
        bus2ip_mstrd_src_rdy_n = 1'b0;
        bus2ip_mstrd_d = 32'h0BADF00D;
        nextCycle();
        busIdle();
        nextCycle();
        checkOutput("ert_done_c4", 32'(ipic_done), 32'd1);
        checkOutput("ert_err_c4",  32'(ipic_error), 32'd1);
        checkOutput("ert_data_c4", single_read_data, 32'h0BADF00D);
        nextCycle();
        checkOutput("ert_err_c5", 32'(ipic_error), 32'd1);

        // Reset in the middle of a read: request drops, no done pulse
        applyStimulus(IPIC_SINGLE_RD, 32'h60000040, 32'h0, 32'h0);
        checkOutput("mrst_req_c1", 32'(ip2bus_mstrd_req), 32'd1);
        nextCycle();
        reset_n = 1'b0;
        nextCycle();
        reset_n = 1'b1;
        checkOutput("mrst_req_c3",  32'(ip2bus_mstrd_req), 32'd0);
        checkOutput("mrst_busy_c3", 32'(ipic_busy), 32'd0);
        checkOutput("mrst_addr_c3", ip2bus_mst_addr, 32'd0);
        for (int c = 4; c <= 6; c++) begin
            nextCycle();
            checkOutput($sformatf("mrst_done_c%0d", c), 32'(ipic_done), 32'd0);
        end
        checkOutput("mrst_stat_rd", 32'(stat_rd_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total_count, bad_count);
        $finish;
    end

endmodule
